md_hazard_ctrl: RTL and testbench
=================================

Name: md_hazard_ctrl

Overview:
- Sequences the multi-cycle multiply/divide resource and its HI/LO registers alongside the 5-stage MIPS pipeline.
- Watches the E-stage instruction (IRE) to launch operations, counts their latency and pulses the HI/LO commit.
- Raises StallMD so the hazard logic freezes F/D and asserts ClearE whenever the D-stage instruction (IRD) needs the busy unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- Clk  in  1  pipeline clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- IRD  in  32  D-stage instruction word
- IRE  in  32  E-stage instruction word; all-zero after ClearE
- Start  out  1  combinational one-cycle launch strobe to the MD datapath
- MdOp  out  2  latched op: 00 mult, 01 multu, 10 div, 11 divu
- Busy  out  1  unit executing
- Done  out  1  one-cycle pulse in the last busy cycle
- HiLoWE  out  1  commit HI/LO at the end of the current cycle; equals Done
- MtHiWE  out  1  E-stage mthi write enable
- MtLoWE  out  1  E-stage mtlo write enable
- StallMD  out  1  D-stage MD hazard stall request
- ProtoErr  out  1  sticky protocol-violation flag

Behaviour:
- Decode uses opcode 000000 (SPECIAL) plus funct:
  - mult 011000, multu 011001, div 011010, divu 011011
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
- IsMdE: IRE is mult/multu/div/divu.
- IsMdD: IRD is any of the eight instructions above.
- Reset values: Cnt=0, MdOp=00, ProtoErr=0. All outputs are 0 under reset, including the combinational ones, which are gated by !Reset.
- State is a 4-bit down-counter Cnt. Busy = (Cnt != 0). There is no separate FSM; the states are IDLE (Cnt=0) and RUN (Cnt>0).
- Start = IsMdE & !Busy, asserted in the same cycle t that the op sits in E.
- On the edge ending cycle t with Start=1:
  - MdOp latches IRE funct[1:0].
  - Cnt loads MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
- While Busy, Cnt decrements by 1 each edge.
- Busy is high in cycles t+1 .. t+N.
- Done = (Cnt == 1), so it is high in cycle t+N only. HiLoWE = Done.
- In cycle t+N+1: Busy=0 and the unit is idle.
- Back-to-back launch:
  - A new Start can occur in cycle t+N+1 at the earliest. Start is never asserted while Busy.
  - A Done cycle with IsMdE=1 is a violation (see ProtoErr); the stall prevents it in a legal flow.
- StallMD = IsMdD & (Start | Busy).
  - mfhi/mflo in D is released in cycle t+N+1 and reaches E in t+N+2, after the HI/LO commit.
  - This covers mult after mult, and mthi/mtlo during a run.
- MtHiWE = IRE is mthi. MtLoWE = IRE is mtlo. Both are purely combinational.
  - Their legal occurrence only when !Busy is guaranteed by StallMD.
  - If either occurs while Busy, the write still happens and ProtoErr sets.
- ProtoErr sets on the edge where (IsMdE | IRE is mthi/mtlo) & Busy. It holds until Reset.
- Division by zero gets no special handling: the full DIV_CYCLES runs and Done still pulses.
- Reset mid-run: Cnt goes to 0 asynchronously. No Done or HiLoWE is produced for the aborted op.
- IRE = 0 (a flushed bubble) never launches anything.

Decomposition:
- Shared package holds:
  - opcode/funct constants, added to the existing macros include: FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO, OP_SPECIAL
  - the MdOp encoding
- One sub-module, md_decode: a combinational classifier for a 32-bit word giving IsMd, IsMfHiLo, IsMtHi, IsMtLo, IsMult.
  - Instantiated twice, once for IRD and once for IRE.
- Counter, ProtoErr and output logic live in md_hazard_ctrl.

Test Plan:
- Reset=1 then IRE=mult encoding 0x00850018 -> all outputs 0. Release Reset -> Start=1 same cycle; Busy cycles 1..5; Done and HiLoWE only in cycle 5; MdOp=00.
- IRE=divu 0x0085001B at t, IRD=mflo 0x00001012 from t -> StallMD=1 for t..t+10; StallMD=0 at t+11; Done at t+10; MdOp=11.
- IRE=mult at t, IRE=mult again at t+6 (legal) -> second Start at t+6, Done at t+5 and t+11, ProtoErr=0. Variant: IRE=mult at t+3 -> no Start, ProtoErr=1 from t+4 and sticky.
- IRE=mthi 0x02000011 while idle -> MtHiWE=1, MtLoWE=0, StallMD=0 for IRD=add. Same with IRE=mtlo -> MtLoWE=1.
- div started, Reset pulsed at cycle t+4 -> Busy=0 immediately, no Done in t+10, Cnt=0.
- IRE=0 bubbles for 20 cycles with IRD=mfhi -> Start=0, Busy=0, StallMD=0 throughout.

Source files
------------

// File: rtl/md_hazard_ctrl_pkg.sv
// md_hazard_ctrl_pkg
// Shared definitions for the multiply/divide hazard controller:
//   - MIPS SPECIAL opcode and the funct codes of the eight HI/LO related
//     instructions (mult, multu, div, divu, mfhi, mthi, mflo, mtlo)
//   - the latched MD operation encoding driven on MdOp
//   - a helper that maps a mult/div funct onto that encoding
package md_hazard_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // The four mult/div funct codes differ only in their two low bits, which
  // are exactly the MdOp encoding.
  function automatic md_op_e md_op_of(input logic [5:0] funct);
    return md_op_e'(funct[1:0]);
  endfunction

endpackage

// File: rtl/md_hazard_ctrl_decode.sv
// md_decode
// Combinational classifier for one 32-bit instruction word.
// Ports:
//   instr      in  32  instruction word
//   is_md      out 1   mult/multu/div/divu (launches the MD unit)
//   is_mfhilo  out 1   mfhi or mflo
//   is_mthi    out 1   mthi
//   is_mtlo    out 1   mtlo
//   is_mult    out 1   mult or multu (selects the multiply latency)
module md_decode
  import md_hazard_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_md,
  output logic        is_mfhilo,
  output logic        is_mthi,
  output logic        is_mtlo,
  output logic        is_mult
);

  // Classify the word by SPECIAL opcode plus funct field.
  always_comb begin
    is_md     = 1'b0;
    is_mfhilo = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    is_mult   = 1'b0;
    if (instr[31:26] == OP_SPECIAL) begin
      case (instr[5:0])
        FUNCT_MULT, FUNCT_MULTU: begin
          is_md   = 1'b1;
          is_mult = 1'b1;
        end
        FUNCT_DIV, FUNCT_DIVU: begin
          is_md = 1'b1;
        end
        FUNCT_MFHI, FUNCT_MFLO: begin
          is_mfhilo = 1'b1;
        end
        FUNCT_MTHI: begin
          is_mthi = 1'b1;
        end
        FUNCT_MTLO: begin
          is_mtlo = 1'b1;
        end
        default: begin
          is_md = 1'b0;
        end
      endcase
    end else begin
      is_md = 1'b0;
    end
  end

endmodule

// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl
// Sequences the multi-cycle multiply/divide unit and HI/LO writes next to a
// 5-stage MIPS pipeline. A mult/div in E launches the unit (Start) when it is
// idle; a 4-bit down-counter tracks the remaining busy cycles, Done/HiLoWE
// pulse in the last one. StallMD holds any HI/LO-related instruction in D
// while the unit is launching or busy.
// Ports:
//   Clk       in  1   pipeline clock, rising edge
//   Reset     in  1   asynchronous active-high reset
//   IRD       in  32  D-stage instruction
//   IRE       in  32  E-stage instruction (zero for a flushed bubble)
//   Start     out 1   launch strobe to the MD datapath (combinational)
//   MdOp      out 2   latched operation (00 mult,01 multu,10 div,11 divu)
//   Busy      out 1   unit executing
//   Done      out 1   last busy cycle
//   HiLoWE    out 1   HI/LO commit at the end of this cycle (= Done)
//   MtHiWE    out 1   mthi write enable from E
//   MtLoWE    out 1   mtlo write enable from E
//   StallMD   out 1   D-stage hazard stall request
//   ProtoErr  out 1   sticky protocol-violation flag
module md_hazard_ctrl
  import md_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRD,
  input  logic [31:0] IRE,
  output logic        Start,
  output logic [1:0]  MdOp,
  output logic        Busy,
  output logic        Done,
  output logic        HiLoWE,
  output logic        MtHiWE,
  output logic        MtLoWE,
  output logic        StallMD,
  output logic        ProtoErr
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [3:0] cnt_q, cnt_d;
  md_op_e     md_op_q, md_op_d;
  logic       proto_err_q, proto_err_d;

  logic is_md_e, is_mfhilo_e, is_mthi_e, is_mtlo_e, is_mult_e;
  logic is_md_d, is_mfhilo_d, is_mthi_d, is_mtlo_d, is_mult_d;
  logic any_md_d_s;
  logic busy_s, start_s, done_s;

  md_decode u_dec_e (
    .instr     (IRE),
    .is_md     (is_md_e),
    .is_mfhilo (is_mfhilo_e),
    .is_mthi   (is_mthi_e),
    .is_mtlo   (is_mtlo_e),
    .is_mult   (is_mult_e)
  );

  md_decode u_dec_d (
    .instr     (IRD),
    .is_md     (is_md_d),
    .is_mfhilo (is_mfhilo_d),
    .is_mthi   (is_mthi_d),
    .is_mtlo   (is_mtlo_d),
    .is_mult   (is_mult_d)
  );

  // The D-stage multiply flag is not needed: any of the eight opcodes stalls.
  assign any_md_d_s = is_md_d | is_mfhilo_d | is_mthi_d | is_mtlo_d | (is_mult_d & 1'b0);

  // Internal status derived from the counter; gated so nothing leaks under reset.
  assign busy_s  = ~Reset & (cnt_q != 4'd0);
  assign done_s  = ~Reset & (cnt_q == 4'd1);
  assign start_s = ~Reset & is_md_e & ~busy_s;

  // Next-state: launch, count down, and latch protocol violations.
  always_comb begin
    cnt_d       = cnt_q;
    md_op_d     = md_op_q;
    proto_err_d = proto_err_q;
    if (start_s) begin
      cnt_d   = is_mult_e ? MULT_CNT : DIV_CNT;
      md_op_d = md_op_of(IRE[5:0]);
    end else if (busy_s) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
    // A Done cycle still counts as busy, so an op arriving then is flagged.
    if (busy_s && (is_md_e || is_mthi_e || is_mtlo_e)) begin
      proto_err_d = 1'b1;
    end else begin
      proto_err_d = proto_err_q;
    end
  end

  // State registers with asynchronous reset (aborts any run in flight).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q       <= 4'd0;
      md_op_q     <= MD_MULT;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      md_op_q     <= md_op_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign Start    = start_s;
  assign Busy     = busy_s;
  assign Done     = done_s;
  assign HiLoWE   = done_s;
  assign MdOp     = Reset ? 2'b00 : md_op_q;
  assign ProtoErr = ~Reset & proto_err_q;
  assign MtHiWE   = ~Reset & is_mthi_e;
  assign MtLoWE   = ~Reset & is_mtlo_e;
  assign StallMD  = ~Reset & any_md_d_s & (start_s | busy_s);

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// tb_md_hazard_ctrl
// Directed bench for md_hazard_ctrl with default latencies (mult 5, div 10).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well before the next edge.
module tb_md_hazard_ctrl;

  localparam logic [31:0] I_MULT = 32'h0085_0018;
  localparam logic [31:0] I_DIV  = 32'h0085_001A;
  localparam logic [31:0] I_DIVU = 32'h0085_001B;
  localparam logic [31:0] I_MFLO = 32'h0000_1012;
  localparam logic [31:0] I_MFHI = 32'h0000_0010;
  localparam logic [31:0] I_MTHI = 32'h0200_0011;
  localparam logic [31:0] I_MTLO = 32'h0200_0013;
  localparam logic [31:0] I_ADD  = 32'h0085_2020;

  logic        Clk;
  logic        Reset;
  logic [31:0] IRD;
  logic [31:0] IRE;
  logic        Start;
  logic [1:0]  MdOp;
  logic        Busy;
  logic        Done;
  logic        HiLoWE;
  logic        MtHiWE;
  logic        MtLoWE;
  logic        StallMD;
  logic        ProtoErr;

  int passed = 0;
  int total  = 0;

  md_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .IRD      (IRD),
    .IRE      (IRE),
    .Start    (Start),
    .MdOp     (MdOp),
    .Busy     (Busy),
    .Done     (Done),
    .HiLoWE   (HiLoWE),
    .MtHiWE   (MtHiWE),
    .MtLoWE   (MtLoWE),
    .StallMD  (StallMD),
    .ProtoErr (ProtoErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // ---- reset: everything zero even with a mult sitting in E ----
    Reset = 1'b1;
    IRE   = I_MULT;
    IRD   = 32'h0;
    #2;
    chk1("rst_start", Start, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_hilowe", HiLoWE, 1'b0);
    chk1("rst_stall", StallMD, 1'b0);
    chk1("rst_mthi", MtHiWE, 1'b0);
    chk1("rst_mtlo", MtLoWE, 1'b0);
    chk1("rst_perr", ProtoErr, 1'b0);
    chk2("rst_mdop", MdOp, 2'b00);
    tick();
    chk1("rst_start_edge", Start, 1'b0);
    chk1("rst_busy_edge", Busy, 1'b0);

    // ---- release: mult launches in the same cycle ----
    Reset = 1'b0;
    #1;
    chk1("mult_start", Start, 1'b1);
    chk1("mult_busy_t", Busy, 1'b0);
    tick();
    IRE = 32'h0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      chk1("mult_busy", Busy, 1'b1);
      chk1("mult_done", Done, (k == 5));
      chk1("mult_hilowe", HiLoWE, (k == 5));
      chk1("mult_nostart", Start, 1'b0);
      chk2("mult_mdop", MdOp, 2'b00);
      tick();
    end
    chk1("mult_idle_busy", Busy, 1'b0);
    chk1("mult_idle_done", Done, 1'b0);

    // ---- divu with mflo waiting in D ----
    IRE = I_DIVU;
    IRD = I_MFLO;
    #1;
    chk1("divu_start", Start, 1'b1);
    chk1("divu_stall_t", StallMD, 1'b1);
    tick();
    IRE = 32'h0;
    #1;
    for (int k = 1; k <= 10; k++) begin
      chk1("divu_stall", StallMD, 1'b1);
      chk1("divu_busy", Busy, 1'b1);
      chk1("divu_done", Done, (k == 10));
      chk1("divu_hilowe", HiLoWE, (k == 10));
      if (k == 1) chk2("divu_mdop", MdOp, 2'b11);
      tick();
    end
    chk1("divu_release", StallMD, 1'b0);
    chk1("divu_idle", Busy, 1'b0);
    chk2("divu_mdop_hold", MdOp, 2'b11);
    IRD = 32'h0;

    // ---- legal back-to-back mult at t+6 ----
    IRE = I_MULT;
    #1;
    chk1("b2b_start1", Start, 1'b1);
    tick();
    IRE = 32'h0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      chk1("b2b_done1", Done, (k == 5));
      tick();
    end
    IRE = I_MULT;
    #1;
    chk1("b2b_start2", Start, 1'b1);
    chk1("b2b_busy_t6", Busy, 1'b0);
    tick();
    IRE = 32'h0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      chk1("b2b_busy2", Busy, 1'b1);
      chk1("b2b_done2", Done, (k == 5));
      tick();
    end
    chk1("b2b_idle", Busy, 1'b0);
    chk1("b2b_perr", ProtoErr, 1'b0);

    // ---- illegal mult at t+3 ----
    IRE = I_MULT;
    #1;
    chk1("ill_start1", Start, 1'b1);
    tick();
    IRE = 32'h0;
    #1;
    tick();
    tick();
    IRE = I_MULT;
    #1;
    chk1("ill_nostart", Start, 1'b0);
    chk1("ill_busy", Busy, 1'b1);
    chk1("ill_perr_t3", ProtoErr, 1'b0);
    tick();
    IRE = 32'h0;
    #1;
    chk1("ill_perr_t4", ProtoErr, 1'b1);
    tick();
    chk1("ill_done_t5", Done, 1'b1);
    tick();
    chk1("ill_idle", Busy, 1'b0);
    chk1("ill_perr_sticky", ProtoErr, 1'b1);

    // ---- mthi / mtlo while idle ----
    IRE = I_MTHI;
    IRD = I_ADD;
    #1;
    chk1("mthi_we", MtHiWE, 1'b1);
    chk1("mthi_lo", MtLoWE, 1'b0);
    chk1("mthi_stall", StallMD, 1'b0);
    chk1("mthi_start", Start, 1'b0);
    IRE = I_MTLO;
    #1;
    chk1("mtlo_we", MtLoWE, 1'b1);
    chk1("mtlo_hi", MtHiWE, 1'b0);
    chk1("mtlo_stall", StallMD, 1'b0);
    IRD = I_MFHI;
    #1;
    chk1("mtlo_mfhi_stall", StallMD, 1'b0);
    tick();
    chk1("mt_perr_sticky", ProtoErr, 1'b1);
    IRE = 32'h0;
    IRD = 32'h0;

    // ---- div aborted by reset at t+4 ----
    #1;
    IRE = I_DIV;
    #1;
    chk1("abort_start", Start, 1'b1);
    tick();
    IRE = 32'h0;
    #1;
    tick();
    tick();
    tick();
    chk1("abort_busy_t4", Busy, 1'b1);
    chk2("abort_mdop", MdOp, 2'b10);
    Reset = 1'b1;
    #1;
    chk1("abort_busy_rst", Busy, 1'b0);
    chk1("abort_perr_rst", ProtoErr, 1'b0);
    chk2("abort_mdop_rst", MdOp, 2'b00);
    tick();
    Reset = 1'b0;
    #1;
    for (int k = 5; k <= 11; k++) begin
      chk1("abort_busy", Busy, 1'b0);
      chk1("abort_done", Done, 1'b0);
      chk1("abort_hilowe", HiLoWE, 1'b0);
      tick();
    end
    chk1("abort_perr", ProtoErr, 1'b0);

    // ---- bubbles in E with mfhi in D ----
    IRE = 32'h0;
    IRD = I_MFHI;
    #1;
    for (int k = 0; k < 20; k++) begin
      chk1("bubble_start", Start, 1'b0);
      chk1("bubble_busy", Busy, 1'b0);
      chk1("bubble_stall", StallMD, 1'b0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
